exu_alu_shared_dpath: RTL and testbench
=======================================

// Module: exu_alu_shared_dpath
// PURPOSE
//  Shared, parametrised ALU datapath serving NREQ requestor channels (ALU, BJP, AGU, ...).
//  Round-robin arbitration, valid/ready handshakes and a registered response port.
//  Full RV integer op set, with a multi-cycle serial shifter for SLL/SRL/SRA.
//  Sits in EXU between the per-unit request decoders and writeback / branch-resolve logic.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, power of 2)
//  NREQ        2   number of requestor channels (1..8)
//  SHIFT_STEP  4   bits shifted per cycle by the serial shifter (power of 2, 1..XLEN)
//  IDW         3   width of rsp_id; must satisfy 2**IDW >= NREQ
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset: synchronous, active-high
//  flush      in   1          abort in-flight op; its response is discarded
//  req_valid  in   NREQ       per-channel request valid
//  req_ready  out  NREQ       per-channel accept (one-hot or zero)
//  req_op     in   NREQ*4     per-channel opcode; channel i at [4i+3:4i]
//  req_op1    in   NREQ*XLEN  per-channel operand 1
//  req_op2    in   NREQ*XLEN  per-channel operand 2 (shift amount = op2[log2(XLEN)-1:0])
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer accept
//  rsp_id     out  IDW        index of the channel that issued the response
//  rsp_res    out  XLEN       result
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Opcodes:
//   0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 MVOP2 (LUI).
//   11-15 are reserved; they complete as one-cycle ops with result 0.
//  Arithmetic:
//   ADD/SUB are modulo 2**XLEN; carry-out is dropped.
//   SLT is signed and SLTU unsigned; both give {XLEN-1 zeros, cmp}.
//   SRA replicates op1[XLEN-1].
//  Reset (rst=1 at a clock edge):
//   state=IDLE, rr_ptr=0, rsp_valid=0, rsp_res=0, rsp_id=0, busy=0, req_ready=0.
//   rst overrides flush and every handshake.
//  FSM states: IDLE, SHIFT, RESP.
//   IDLE:
//    - The grant goes to the first valid channel, searching from rr_ptr upward with wrap.
//    - req_ready[g]=1 combinationally for the granted channel only.
//    - Accepting the request sets rr_ptr <= (g+1) mod NREQ.
//    - Non-shift op: the result is registered and the FSM goes to RESP.
//    - Shift with amount 0: rsp_res=op1 and the FSM goes to RESP.
//    - Shift with amount s>0: op1, s, op type and id are latched and the FSM goes to SHIFT.
//   SHIFT:
//    - Each cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
//    - Goes to RESP when remaining reaches 0.
//   RESP:
//    - rsp_valid=1; rsp_res and rsp_id stay stable until rsp_valid & rsp_ready.
//    - On handshake go to IDLE. The next request is accepted no earlier than the following cycle.
//  Request handshake:
//   - req_ready is 0 outside IDLE and during flush.
//   - A requestor holds valid and payload stable until it sees ready.
//  Latency (accept at edge T):
//   - Non-shift ops, and shifts with amount 0: rsp_valid from T+1.
//   - Shift by s: rsp_valid from T+1+ceil(s/SHIFT_STEP).
//   - Throughput with rsp_ready held high: one non-shift op every 2 cycles.
//  Flush:
//   - In SHIFT or RESP: go to IDLE next edge with rsp_valid=0 and no response delivered.
//   - In IDLE: no accept that cycle.
//   - rr_ptr is unchanged by flush.
//  Simultaneous events:
//   - rsp handshake and flush in the same cycle: the handshake completes (delivered), then IDLE.
//   - req_valid from every channel: strict rotation, so no channel waits more than NREQ grants.
// TESTING
//  1. ADD ch0, op1=0x7FFFFFFF, op2=1 -> rsp_valid at T+1, rsp_res=0x80000000, rsp_id=0.
//  2. ch0 and ch1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches its request.
//  3. SRA ch1, op1=0x80000000, op2=31, STEP=4 -> rsp_valid at T+9, rsp_res=0xFFFFFFFF; SLL by 0 -> T+1, res=op1.
//  4. SLT op1=0xFFFFFFFF, op2=1 -> 1; SLTU with the same operands -> 0; SUB 0-1 -> 0xFFFFFFFF; op 12 -> 0.
//  5. rsp_ready=0 for 5 cycles -> rsp_res/rsp_id stable, req_ready=0, busy=1; release -> IDLE next cycle.
//  6. Flush at SHIFT cycle 2 -> no rsp_valid; next request accepted with the correct result.
//     rst mid-RESP -> all outputs at reset values after the edge.

Source files
------------

// File: rtl/exu_alu_shared_dpath.sv
// Shared ALU datapath for NREQ requestors: round-robin grant, registered response,
// serial shifter. States: IDLE | waiting for a request; SHIFT | serial shift in progress; RESP | holding response
module exu_alu_shared_dpath #(
  parameter int XLEN       = 32,
  parameter int NREQ       = 2,
  parameter int SHIFT_STEP = 4,
  parameter int IDW        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_res,
  output logic                 busy
);

  localparam int SW = $clog2(XLEN);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MVOP2 = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [3:0]        sh_op_q, sh_op_d;
  logic [SW-1:0]     sh_rem_q, sh_rem_d;

  logic              gnt_found;
  logic [PW-1:0]     gnt_idx;
  int                cand;
  int                gnt_int;
  logic              accept;
  logic [3:0]        sel_op;
  logic [XLEN-1:0]   sel_a, sel_b;
  logic [SW-1:0]     sel_amt;
  logic              sel_is_shift;
  logic [SW:0]       step_w;
  logic [XLEN-1:0]   shifted;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:   r = a ^ b;
      OP_OR:    r = a | b;
      OP_AND:   r = a & b;
      OP_MVOP2: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Lowest rotation offset from rr_ptr wins, hence the descending search.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  assign gnt_int = int'(gnt_idx);
  assign accept  = !rst && (state_q == S_IDLE) && !flush && gnt_found;

  always_comb begin
    sel_op       = req_op[gnt_int*4 +: 4];
    sel_a        = req_op1[gnt_int*XLEN +: XLEN];
    sel_b        = req_op2[gnt_int*XLEN +: XLEN];
    sel_amt      = sel_b[SW-1:0];
    sel_is_shift = (sel_op == OP_SLL) || (sel_op == OP_SRL) || (sel_op == OP_SRA);
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    step_w = ({1'b0, sh_rem_q} >= STEP_W) ? STEP_W : {1'b0, sh_rem_q};
    case (sh_op_q)
      OP_SLL:  shifted = res_q << step_w;
      OP_SRL:  shifted = res_q >> step_w;
      default: shifted = XLEN'($signed(res_q) >>> step_w);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    res_d    = res_q;
    id_d     = id_q;
    sh_op_d  = sh_op_q;
    sh_rem_d = sh_rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rr_ptr_d = (gnt_int == NREQ-1) ? '0 : gnt_idx + 1'b1;
          id_d     = IDW'(gnt_idx);
          if (sel_is_shift && (sel_amt != '0)) begin
            state_d  = S_SHIFT;
            res_d    = sel_a;
            sh_rem_d = sel_amt;
            sh_op_d  = sel_op;
          end else begin
            state_d = S_RESP;
            res_d   = sel_is_shift ? sel_a : alu_f(sel_op, sel_a, sel_b);
          end
        end
      end
      S_SHIFT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          res_d    = shifted;
          sh_rem_d = sh_rem_q - step_w[SW-1:0];
          if (sh_rem_q == step_w[SW-1:0]) state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A handshake coinciding with flush still counts as delivered.
        if (rsp_ready || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      res_q    <= '0;
      id_q     <= '0;
      sh_op_q  <= '0;
      sh_rem_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      res_q    <= res_d;
      id_q     <= id_d;
      sh_op_q  <= sh_op_d;
      sh_rem_q <= sh_rem_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_res   = res_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_exu_alu_shared_dpath.sv
// Directed bench for exu_alu_shared_dpath (XLEN=32, NREQ=2, SHIFT_STEP=4, IDW=3).
module tb_exu_alu_shared_dpath;
  localparam int XLEN = 32;
  localparam int NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ*XLEN-1:0] req_op1;
  logic [NREQ*XLEN-1:0] req_op2;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_id;
  logic [XLEN-1:0]      rsp_res;
  logic                 busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exu_alu_shared_dpath #(.XLEN(32), .NREQ(2), .SHIFT_STEP(4), .IDW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[ch]        = 1'b1;
    req_op[ch*4 +: 4]    = op;
    req_op1[ch*32 +: 32] = a;
    req_op2[ch*32 +: 32] = b;
  endtask

  task automatic clr_req(input int ch);
    req_valid[ch] = 1'b0;
  endtask

  function automatic logic [1:0] oh(input int ch);
    logic [1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Single-channel op with rsp_ready high; ncyc = ceil(shift/STEP), 0 for one-cycle ops.
  task automatic run_op(input string tag, input int ch, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int ncyc);
    set_req(ch, op, a, b);
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(oh(ch)));
    tick();
    clr_req(ch);
    for (int i = 0; i < ncyc; i++) begin
      chk({tag, ".wait"}, 64'(rsp_valid), 64'd0);
      tick();
    end
    chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ".id"}, 64'(rsp_id), 64'(ch));
    chk({tag, ".res"}, 64'(rsp_res), 64'(exp_res));
    tick();
    chk({tag, ".done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_order [4];
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_op = '0; req_op1 = '0; req_op2 = '0;

    // Reset, with a request pending that must not be acknowledged
    set_req(0, 4'd0, 32'h7FFF_FFFF, 32'h1);
    tick(); tick();
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.res",   64'(rsp_res), 64'd0);
    chk("rst.id",    64'(rsp_id), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);

    // ADD overflow wraps, response in the cycle after accept
    rst = 1'b0;
    #1;
    chk("add.ready", 64'(req_ready), 64'd1);
    tick();
    clr_req(0);
    chk("add.valid", 64'(rsp_valid), 64'd1);
    chk("add.res",   64'(rsp_res), 64'h8000_0000);
    chk("add.id",    64'(rsp_id), 64'd0);
    chk("add.busy",  64'(busy), 64'd1);
    tick();
    chk("add.idle",  64'(busy), 64'd0);

    // Both channels valid: rr_ptr is 1 after the ch0 grant, so 1,0,1,0
    exp_order[0] = 2'd1; exp_order[1] = 2'd0; exp_order[2] = 2'd1; exp_order[3] = 2'd0;
    set_req(0, 4'd0, 32'd5, 32'd3);
    set_req(1, 4'd4, 32'hF0, 32'hFF);
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr.ready", 64'(req_ready), 64'(oh(int'(exp_order[g]))));
      tick();
      chk("rr.valid", 64'(rsp_valid), 64'd1);
      chk("rr.id", 64'(rsp_id), 64'(exp_order[g]));
      chk("rr.res", 64'(rsp_res), (exp_order[g] == 2'd0) ? 64'h8 : 64'h0F);
      tick();
    end
    clr_req(0); clr_req(1);

    // Shifts
    run_op("sra31", 1, 4'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 8);
    run_op("sll0",  0, 4'd7, 32'h1234_5678, 32'h20, 32'h1234_5678, 0);
    run_op("srl5",  1, 4'd8, 32'hF000_0000, 32'd5, 32'h0780_0000, 2);
    run_op("sll4",  0, 4'd7, 32'h1, 32'h24, 32'h10, 1);
    run_op("sra3",  1, 4'd9, 32'h4000_0000, 32'd3, 32'h0800_0000, 1);

    // Compare / logic / reserved
    run_op("slt",   0, 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op("sltu",  1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("sub",   0, 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("rsv12", 1, 4'd12, 32'h1234, 32'h5678, 32'd0, 0);
    run_op("and",   0, 4'd6, 32'hF0F0, 32'hFF00, 32'hF000, 0);
    run_op("or",    1, 4'd5, 32'hF0F0, 32'h0F00, 32'hFFF0, 0);
    run_op("mvop2", 0, 4'd10, 32'hDEAD, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);
    run_op("addc",  1, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);

    // Back-pressure: response held, no accepts while RESP
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd10, 32'd20);
    #1;
    chk("bp.ready0", 64'(req_ready), 64'd1);
    tick();
    clr_req(0);
    set_req(1, 4'd5, 32'd3, 32'd4);
    repeat (5) begin
      #1;
      chk("bp.valid", 64'(rsp_valid), 64'd1);
      chk("bp.res",   64'(rsp_res), 64'd30);
      chk("bp.id",    64'(rsp_id), 64'd0);
      chk("bp.ready", 64'(req_ready), 64'd0);
      chk("bp.busy",  64'(busy), 64'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.ready_hs", 64'(req_ready), 64'd0);
    tick();
    chk("bp.released", 64'(rsp_valid), 64'd0);
    #1;
    chk("bp.next_ready", 64'(req_ready), 64'd2);
    tick();
    clr_req(1);
    chk("bp.next_res", 64'(rsp_res), 64'd7);
    chk("bp.next_id",  64'(rsp_id), 64'd1);
    tick();

    // Flush during the second SHIFT cycle
    set_req(0, 4'd8, 32'hFFFF_FFFF, 32'd16);
    #1;
    tick();
    clr_req(0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.busy",  64'(busy), 64'd0);
    chk("fl.valid", 64'(rsp_valid), 64'd0);
    repeat (6) begin
      tick();
      chk("fl.quiet", 64'(rsp_valid), 64'd0);
    end
    set_req(0, 4'd0, 32'd1, 32'd1);
    set_req(1, 4'd0, 32'd2, 32'd3);
    #1;
    chk("fl.rr", 64'(req_ready), 64'd2);
    tick();
    clr_req(0); clr_req(1);
    chk("fl.res", 64'(rsp_res), 64'd5);
    chk("fl.id",  64'(rsp_id), 64'd1);
    tick();

    // Flush in IDLE blocks the accept
    set_req(0, 4'd0, 32'd7, 32'd8);
    flush = 1'b1;
    #1;
    chk("fli.ready", 64'(req_ready), 64'd0);
    tick();
    chk("fli.busy", 64'(busy), 64'd0);
    flush = 1'b0;
    #1;
    chk("fli.ready2", 64'(req_ready), 64'd1);
    tick();
    clr_req(0);
    chk("fli.res", 64'(rsp_res), 64'd15);
    tick();

    // Flush in RESP discards the response
    rsp_ready = 1'b0;
    set_req(1, 4'd4, 32'hAA, 32'h55);
    #1;
    tick();
    clr_req(1);
    chk("flr.valid", 64'(rsp_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flr.dropped", 64'(rsp_valid), 64'd0);
    chk("flr.busy",    64'(busy), 64'd0);

    // Reset while in RESP; rr_ptr is 1 before it, 0 after
    set_req(0, 4'd0, 32'h100, 32'h23);
    #1;
    tick();
    clr_req(0);
    chk("rr2.valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rr2.rvalid", 64'(rsp_valid), 64'd0);
    chk("rr2.rres",   64'(rsp_res), 64'd0);
    chk("rr2.rid",    64'(rsp_id), 64'd0);
    chk("rr2.rbusy",  64'(busy), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 32'd4, 32'd4);
    set_req(1, 4'd0, 32'd9, 32'd9);
    #1;
    chk("rr2.ptr", 64'(req_ready), 64'd1);
    tick();
    clr_req(0); clr_req(1);
    chk("rr2.res", 64'(rsp_res), 64'd8);
    chk("rr2.id",  64'(rsp_id), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
